pipe_stage_skid: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage MIPS core, replacing the fixed-field, enable-only stage registers. It carries an instruction word, an opaque payload bus (PC, PC+8, ALU result, RT and similar fields), a destination register address and a Tnew value. It adds a valid/ready handshake with a two-entry skid buffer, synchronous flush for bubble insertion, automatic Tnew ageing, forwarding qualification and a stall counter. It sits between any two stages (D/E, E/M, M/W).

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_entry.sv | 64 ++++++
 rtl/pipe_stage_skid.sv | 125 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for MIPS inter-stage pipeline registers.
// Payload offsets let E/M/W users slice out_payload the same way everywhere.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;

    localparam int RADDR_W   = 5;
    localparam int TNEW_W    = 2;
    localparam int PAYLOAD_W = 128;

    localparam int FIELD_W     = 32;
    localparam int PL_PC_LSB   = 0;
    localparam int PL_PC8_LSB  = 32;
    localparam int PL_ALU_LSB  = 64;
    localparam int PL_RT_LSB   = 96;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: valid plus instr/payload/raddr/tnew. Load takes effect at the next edge.
// Tnew is aged (saturating decrement) on load only when i_age is set; a held entry never ages.
module pipe_entry #(
    parameter int PAYLOAD_W = 128,
    parameter int RADDR_W   = 5,
    parameter int TNEW_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic                 i_drop,
    input  logic                 i_age,
    input  logic [31:0]          i_instr,
    input  logic [PAYLOAD_W-1:0] i_payload,
    input  logic [RADDR_W-1:0]   i_raddr,
    input  logic [TNEW_W-1:0]    i_tnew,
    output logic                 o_valid,
    output logic [31:0]          o_instr,
    output logic [PAYLOAD_W-1:0] o_payload,
    output logic [RADDR_W-1:0]   o_raddr,
    output logic [TNEW_W-1:0]    o_tnew
);

    logic                 r_valid;
    logic [31:0]          r_instr;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [RADDR_W-1:0]   r_raddr;
    logic [TNEW_W-1:0]    r_tnew;
    logic [TNEW_W-1:0]    w_tnew_aged;
    logic [TNEW_W-1:0]    w_tnew_d;

    assign w_tnew_aged = (i_tnew == '0) ? '0 : i_tnew - TNEW_W'(1);
    assign w_tnew_d    = i_age ? w_tnew_aged : i_tnew;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_instr   <= '0;
            r_payload <= '0;
            r_raddr   <= '0;
            r_tnew    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_raddr <= '0;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_instr   <= i_instr;
            r_payload <= i_payload;
            r_raddr   <= i_raddr;
            r_tnew    <= w_tnew_d;
        end else if (i_drop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_instr   = r_instr;
    assign o_payload = r_payload;
    assign o_raddr   = r_raddr;
    assign o_tnew    = r_tnew;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with 2-entry skid; 1-cycle latency, full throughput.
// in_ready is registered (!skid valid), so backpressure reaches upstream one cycle late and the skid absorbs it.
module pipe_stage_skid #(
    parameter int PAYLOAD_W   = pipe_pkg::PAYLOAD_W,
    parameter int RADDR_W     = pipe_pkg::RADDR_W,
    parameter int TNEW_W      = pipe_pkg::TNEW_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PAYLOAD_W-1:0]   in_payload,
    input  logic [RADDR_W-1:0]     in_raddr,
    input  logic [TNEW_W-1:0]      in_tnew,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [PAYLOAD_W-1:0]   out_payload,
    output logic [RADDR_W-1:0]     out_raddr,
    output logic [TNEW_W-1:0]      out_tnew,
    output logic                   fwd_en,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    import pipe_pkg::*;

    logic                   w_m_valid;
    logic [31:0]            w_m_instr;
    logic [PAYLOAD_W-1:0]   w_m_payload;
    logic [RADDR_W-1:0]     w_m_raddr;
    logic [TNEW_W-1:0]      w_m_tnew;

    logic                   w_s_valid;
    logic [31:0]            w_s_instr;
    logic [PAYLOAD_W-1:0]   w_s_payload;
    logic [RADDR_W-1:0]     w_s_raddr;
    logic [TNEW_W-1:0]      w_s_tnew;

    logic                   w_main_free;
    logic                   w_in_fire;
    logic                   w_m_load;
    logic                   w_s_load;
    logic [31:0]            w_m_d_instr;
    logic [PAYLOAD_W-1:0]   w_m_d_payload;
    logic [RADDR_W-1:0]     w_m_d_raddr;
    logic [TNEW_W-1:0]      w_m_d_tnew;

    logic [STALL_CNT_W-1:0] r_stall_cnt;

    assign in_ready    = !w_s_valid;
    assign w_in_fire   = in_valid && in_ready;
    assign w_main_free = !w_m_valid || out_ready;

    // Skid drains first; in_fire cannot coincide with a full skid since in_ready is low then.
    assign w_m_load      = w_main_free && (w_s_valid || w_in_fire);
    assign w_s_load      = !w_main_free && w_in_fire;
    assign w_m_d_instr   = w_s_valid ? w_s_instr   : in_instr;
    assign w_m_d_payload = w_s_valid ? w_s_payload : in_payload;
    assign w_m_d_raddr   = w_s_valid ? w_s_raddr   : in_raddr;
    assign w_m_d_tnew    = w_s_valid ? w_s_tnew    : in_tnew;

    pipe_entry #(
        .PAYLOAD_W (PAYLOAD_W),
        .RADDR_W   (RADDR_W),
        .TNEW_W    (TNEW_W)
    ) u_main (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (flush),
        .i_load    (w_m_load),
        .i_drop    (w_main_free),
        .i_age     (!w_s_valid),
        .i_instr   (w_m_d_instr),
        .i_payload (w_m_d_payload),
        .i_raddr   (w_m_d_raddr),
        .i_tnew    (w_m_d_tnew),
        .o_valid   (w_m_valid),
        .o_instr   (w_m_instr),
        .o_payload (w_m_payload),
        .o_raddr   (w_m_raddr),
        .o_tnew    (w_m_tnew)
    );

    pipe_entry #(
        .PAYLOAD_W (PAYLOAD_W),
        .RADDR_W   (RADDR_W),
        .TNEW_W    (TNEW_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (flush),
        .i_load    (w_s_load),
        .i_drop    (w_main_free),
        .i_age     (1'b1),
        .i_instr   (in_instr),
        .i_payload (in_payload),
        .i_raddr   (in_raddr),
        .i_tnew    (in_tnew),
        .o_valid   (w_s_valid),
        .o_instr   (w_s_instr),
        .o_payload (w_s_payload),
        .o_raddr   (w_s_raddr),
        .o_tnew    (w_s_tnew)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_m_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign out_valid   = w_m_valid;
    assign out_instr   = w_m_valid ? w_m_instr : NOP_INSTR;
    assign out_payload = w_m_payload;
    assign out_raddr   = w_m_valid ? w_m_raddr : '0;
    assign out_tnew    = w_m_tnew;
    assign fwd_en      = w_m_valid && (w_m_raddr != '0) && (w_m_tnew == '0);
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboarded random/directed bench for pipe_stage_skid against a queue-based model.
module tb_pipe_stage_skid;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_instr;
    logic [127:0] in_payload;
    logic [4:0]   in_raddr;
    logic [1:0]   in_tnew;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_instr;
    logic [127:0] out_payload;
    logic [4:0]   out_raddr;
    logic [1:0]   out_tnew;
    logic         fwd_en;
    logic [15:0]  stall_cnt;

    pipe_stage_skid dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_payload  (in_payload),
        .in_raddr    (in_raddr),
        .in_tnew     (in_tnew),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_payload (out_payload),
        .out_raddr   (out_raddr),
        .out_tnew    (out_tnew),
        .fwd_en      (fwd_en),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  instr;
        logic [127:0] payload;
        logic [4:0]   raddr;
        logic [1:0]   tnew;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_stall = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] aged(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Output monitor: the stage holds exactly the model's queue; the head is on the outputs.
    always @(negedge clk) begin
        int    held;
        beat_t b;
        if (!reset) begin
            held = exp_q.size();
            check("out_valid", out_valid, held > 0);
            check("in_ready", in_ready, held < 2);
            check("stall_cnt", stall_cnt, exp_stall);
            if (held > 0) begin
                b = exp_q[0];
                check("out_instr", out_instr, b.instr);
                check("out_payload", out_payload, b.payload);
                check("out_raddr", out_raddr, b.raddr);
                check("out_tnew", out_tnew, b.tnew);
                check("fwd_en", fwd_en, (b.raddr != 0) && (b.tnew == 0));
                if (!out_ready) exp_stall++;
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                check("idle_instr", out_instr, 0);
                check("idle_raddr", out_raddr, 0);
                check("idle_fwd_en", fwd_en, 0);
            end
            if (flush) exp_q.delete();
        end
    end

    // Input recorder: every accepted, unflushed beat is expected later, with tnew aged once.
    always @(negedge clk) begin
        if (!reset) begin
            #1;
            if (in_valid && in_ready && !flush)
                exp_q.push_back('{in_instr, in_payload, in_raddr, aged(in_tnew)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [4:0] ra, input logic [1:0] tn);
        in_valid   = v;
        in_instr   = instr;
        in_payload = {$urandom, $urandom, $urandom, $urandom};
        in_raddr   = ra;
        in_tnew    = tn;
    endtask

    task automatic random_phase(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(($urandom % 3) != 0, $urandom, 5'($urandom), 2'($urandom_range(0, 3)));
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 20) == 0;
            step();
        end
        flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 2'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_out_raddr", out_raddr, 0);
        check("rst_out_tnew", out_tnew, 0);
        check("rst_fwd_en", fwd_en, 0);
        check("rst_stall_cnt", stall_cnt, 0);

        // Single beat
        out_ready = 1'b1;
        drive(1'b1, 32'h00221820, 5'd3, 2'd2);
        step();
        in_valid = 1'b0;
        check("single_valid", out_valid, 1);
        check("single_tnew", out_tnew, 1);
        check("single_fwd", fwd_en, 0);
        step();
        check("single_gone", out_valid, 0);

        // Streaming
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h1000 + i, 5'(i + 1), 2'(i));
            step();
            check("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        repeat (2) step();

        // Backpressure: two beats, three stalled cycles
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA0001, 5'd7, 2'd1);
        step();
        drive(1'b1, 32'hAAAA0002, 5'd8, 2'd3);
        step();
        in_valid = 1'b0;
        step();
        step();
        check("bp_stall_cnt", stall_cnt, 3);
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        repeat (3) step();

        // Flush with both entries full and a beat offered
        out_ready = 1'b0;
        drive(1'b1, 32'hBBBB0001, 5'd4, 2'd0);
        step();
        drive(1'b1, 32'hBBBB0002, 5'd6, 2'd0);
        step();
        drive(1'b1, 32'hBBBB0003, 5'd9, 2'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_out_instr", out_instr, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();

        // Ageing and forwarding qualification
        drive(1'b1, 32'hCCCC0001, 5'd5, 2'd1);
        step();
        check("age_tnew1", out_tnew, 0);
        check("age_fwd1", fwd_en, 1);
        drive(1'b1, 32'hCCCC0002, 5'd0, 2'd1);
        step();
        check("age_fwd_r0", fwd_en, 0);
        drive(1'b1, 32'hCCCC0003, 5'd9, 2'd0);
        step();
        check("age_tnew0", out_tnew, 0);
        check("age_fwd0", fwd_en, 1);
        drive(1'b1, 32'hCCCC0004, 5'd9, 2'd3);
        step();
        check("age_tnew3", out_tnew, 2);
        in_valid = 1'b0;
        step();

        random_phase(3000);

        // Async reset pulse between edges with the stage full
        out_ready = 1'b0;
        drive(1'b1, 32'hDDDD0001, 5'd1, 2'd0);
        step();
        drive(1'b1, 32'hDDDD0002, 5'd2, 2'd0);
        step();
        in_valid = 1'b0;
        check("pre_reset_full", in_ready, 0);
        #1 reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_out_instr", out_instr, 0);
        check("arst_out_raddr", out_raddr, 0);
        check("arst_out_tnew", out_tnew, 0);
        check("arst_fwd_en", fwd_en, 0);
        check("arst_stall_cnt", stall_cnt, 0);
        exp_q.delete();
        exp_stall = 0;
        #1 reset = 1'b0;

        random_phase(1000);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("drain_empty", exp_q.size(), 0);
        check("drain_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
